// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl
// Ports: clk/rst (async active-high); rdy freezes the block; flush drops the in-flight
// fetch response; inv_all clears every valid bit; if_req/if_addr/if_ready form the fetch
// handshake; inst_valid/inst return the word; mem_req/mem_addr/mem_done/mem_data fill a miss.
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        inv_all,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - 2 - INDEX_BITS;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic drop;
  logic [INDEX_BITS-1:0] idx, fidx;
  logic [TAG_W-1:0] tg, ftg;
  logic hit, accept, fill;
  logic unused_bits;
  assign idx = if_addr[INDEX_BITS+1:2];
  assign tg = if_addr[ADDR_BITS-1:INDEX_BITS+2];
  // The fill target comes from the latched miss address, not the live fetch address.
  assign fidx = mem_addr[INDEX_BITS+1:2];
  assign ftg = mem_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign unused_bits = ^{if_addr[31:ADDR_BITS], if_addr[1:0]};
  assign hit = valid[idx] && tags[idx] == tg;
  assign if_ready = state == IDLE && rdy && !flush && !inv_all;
  assign accept = if_req && if_ready;
  assign fill = rdy && state == WAIT && mem_done;
  always_comb begin
    state_n = (accept && !hit) ? WAIT : fill ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      inst_valid <= 1'b0;
      inst <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      drop <= 1'b0;
    end else if (rdy) begin
      inst_valid <= 1'b0;
      if (accept && hit) begin
        inst <= data[idx];
        inst_valid <= 1'b1;
      end
      if (accept && !hit) begin
        mem_addr <= {if_addr[31:2], 2'b00};
        mem_req <= 1'b1;
        drop <= 1'b0;
      end
      if (state == WAIT && flush) drop <= 1'b1;
      if (fill) begin
        mem_req <= 1'b0;
        inst <= (drop || flush) ? inst : mem_data;
        inst_valid <= !drop && !flush;
      end
      if (inv_all) valid <= '0;
      // The memory read cannot be aborted, so its line is marked valid even over inv_all.
      if (fill) valid[fidx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data[fidx] <= mem_data;
      tags[fidx] <= ftg;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache against a line-level reference model
module tb_icache;
  logic clk = 1'b0;
  logic rst, rdy, flush, inv_all, if_req, if_ready, inst_valid, mem_req, mem_done;
  logic [31:0] if_addr, inst, mem_addr, mem_data;
  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .inv_all(inv_all),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .inst_valid(inst_valid), .inst(inst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  bit mv [64];
  logic [9:0] mt [64];
  logic [31:0] md [64];
  logic [31:0] backing [logic [31:0]];
  bit mem_auto = 1'b1;
  int mem_lat = 9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : ((a * 32'h9E3779B1) ^ 32'h13);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[a[7:2]] && mt[a[7:2]] == a[17:8];
  endfunction

  task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
    mv[a[7:2]] = 1'b1;
    mt[a[7:2]] = a[17:8];
    md[a[7:2]] = d;
  endtask

  task automatic m_inv;
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (inst_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_inst: got %h expected no pulse", inst);
      end else chk("inst", inst, exp_q.pop_front());
    end
  end

  initial begin
    mem_done = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_auto) begin
        automatic logic [31:0] a;
        automatic int l;
        a = mem_addr;
        l = mem_lat != 0 ? mem_lat : int'($urandom_range(1, 8));
        for (int i = 1; i < l; i++) begin
          @(negedge clk);
          chk("mem_req_held", mem_req, 1);
          chk("mem_addr_held", mem_addr, a);
        end
        mem_data = mem_word(a);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
      end
    end
  end

  task automatic drain;
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a);
    bit h;
    int t = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = a;
    #1;
    while (!if_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("if_ready", if_ready, 1);
    h = m_hit(a);
    if (h) exp_q.push_back(md[a[7:2]]);
    else begin
      exp_q.push_back(mem_word(a));
      m_fill(a, mem_word(a));
    end
    @(negedge clk);
    if_req = 1'b0;
    chk("hit_pulse", inst_valid, h);
    chk("mem_req", mem_req, !h);
    if (!h) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    drain;
  endtask

  task automatic inv_pulse;
    @(negedge clk);
    inv_all = 1'b1;
    #1;
    chk("inv_blocks_ready", if_ready, 0);
    @(negedge clk);
    inv_all = 1'b0;
    m_inv;
  endtask

  task automatic start_miss(input logic [31:0] a);
    mem_auto = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = a;
    #1;
    chk("miss_ready", if_ready, 1);
    @(negedge clk);
    if_req = 1'b0;
    chk("miss_req", mem_req, 1);
    chk("miss_addr", mem_addr, a);
  endtask

  task automatic finish_miss(input logic [31:0] a, input logic [31:0] d, input bit deliver, input bit fl);
    if (deliver) exp_q.push_back(d);
    mem_data = d;
    mem_done = 1'b1;
    flush = fl;
    @(negedge clk);
    mem_done = 1'b0;
    flush = 1'b0;
    chk("fill_req_drop", mem_req, 0);
    m_fill(a, d);
    drain;
    mem_auto = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; inv_all = 1'b0; if_req = 1'b0; if_addr = '0;
    backing[32'h0] = 32'h00000513;
    backing[32'h4] = 32'hAAAA0001;
    backing[32'h20] = 32'h12345678;
    m_inv;
    #12;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_if_ready", if_ready, 1);
    fetch(32'h0);
    mem_lat = 0;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h104);
    fetch(32'h4);
    fetch(32'h0);
    fetch(32'h8);
    @(negedge clk);
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr = 32'(i * 4);
      #1;
      chk("b2b_ready", if_ready, 1);
      exp_q.push_back(md[i]);
      @(negedge clk);
      chk("b2b_valid", inst_valid, 1);
    end
    if_req = 1'b0;
    drain;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", if_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    inv_pulse;
    start_miss(32'h20);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    finish_miss(32'h20, 32'h12345678, 1'b0, 1'b0);
    fetch(32'h20);
    start_miss(32'h24);
    @(negedge clk);
    finish_miss(32'h24, 32'h0BADF00D, 1'b0, 1'b1);
    fetch(32'h24);
    start_miss(32'h40);
    @(negedge clk);
    rdy = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush = 1'b0;
      chk("frz_mem_req", mem_req, 1);
      chk("frz_mem_addr", mem_addr, 32'h40);
      chk("frz_if_ready", if_ready, 0);
    end
    rdy = 1'b1;
    finish_miss(32'h40, 32'hCAFE0040, 1'b1, 1'b0);
    fetch(32'h40);
    fetch(32'h0);
    inv_pulse;
    fetch(32'h0);
    start_miss(32'h80);
    @(negedge clk);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    m_inv;
    finish_miss(32'h80, 32'h00800080, 1'b1, 1'b0);
    fetch(32'h80);
    fetch(32'h0);
    start_miss(32'h100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_inst_valid", inst_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    m_inv;
    mem_data = 32'hDEADBEEF;
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_req", mem_req, 0);
    chk("stray_done_ready", if_ready, 1);
    mem_auto = 1'b1;
    fetch(32'h100);
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 15) == 0) inv_pulse;
      else fetch((32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
